// File: rtl/modseg_pkg.sv
// Shared types and constants for the segment-select pipeline.
package modseg_pkg;

  typedef enum logic [1:0] {
    MODE_NORM  = 2'd0,
    MODE_INV   = 2'd1,
    MODE_CARR  = 2'd2,
    MODE_BLANK = 2'd3
  } mode_t;

  localparam int MODSEG_CNT_W = 16;

endpackage

// File: rtl/modseg_lane.sv
// One channel: compare the symbol against the shared zero word and pick a segment.
module modseg_lane
  import modseg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] sym,
  input  logic [WIDTH-1:0] zero,
  input  logic [WIDTH-1:0] ref_p,
  input  logic [WIDTH-1:0] ref_m,
  input  mode_t            mode,
  output logic [WIDTH-1:0] seg,
  output logic             sel_else
);

  logic eq;

  assign eq = (sym == zero);

  always_comb begin
    seg      = ref_p;
    sel_else = 1'b0;
    case (mode)
      MODE_NORM: begin
        seg      = eq ? ref_p : ref_m;
        sel_else = ~eq;
      end
      MODE_INV: begin
        seg      = eq ? ref_m : ref_p;
        sel_else = eq;
      end
      MODE_CARR: begin
        seg      = ref_p;
        sel_else = 1'b0;
      end
      MODE_BLANK: begin
        seg      = '0;
        sel_else = 1'b0;
      end
      default: begin
        seg      = '0;
        sel_else = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mod_segment_pipe.sv
// Multi-channel segment selector with a PIPE-deep globally stalled pipeline.
// Optional selection counters (cnt_if / cnt_else) are built when MODSEG_CNT_EN is defined.
module mod_segment_pipe
  import modseg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int PIPE  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*WIDTH-1:0]    in_bits,
  input  logic [WIDTH-1:0]        zero,
  input  logic [NCH*WIDTH-1:0]    ref_p,
  input  logic [NCH*WIDTH-1:0]    ref_m,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*WIDTH-1:0]    seg_out,
  output logic [NCH-1:0]          sel_else
`ifdef MODSEG_CNT_EN
  ,
  output logic [MODSEG_CNT_W-1:0] cnt_if,
  output logic [MODSEG_CNT_W-1:0] cnt_else
`endif
);

  logic                 advance;
  mode_t                mode_c;
  logic [NCH*WIDTH-1:0] seg_c;
  logic [NCH-1:0]       sel_c;

  logic                 vld_p [PIPE];
  logic [NCH*WIDTH-1:0] seg_p [PIPE];
  logic [NCH-1:0]       sel_p [PIPE];

  // Whole pipe moves together; it may move whenever the last slot is empty or draining.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign mode_c   = mode_t'(mode);

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    modseg_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .sym      (in_bits[k*WIDTH +: WIDTH]),
      .zero     (zero),
      .ref_p    (ref_p[k*WIDTH +: WIDTH]),
      .ref_m    (ref_m[k*WIDTH +: WIDTH]),
      .mode     (mode_c),
      .seg      (seg_c[k*WIDTH +: WIDTH]),
      .sel_else (sel_c[k])
    );
  end

  // Stage 0 captures the selected beat at accept; stages 1..PIPE-1 shift it toward the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) begin
        vld_p[i] <= 1'b0;
        seg_p[i] <= '0;
        sel_p[i] <= '0;
      end
    end else if (advance) begin
      vld_p[0] <= in_valid;
      seg_p[0] <= seg_c;
      sel_p[0] <= sel_c;
      for (int i = 1; i < PIPE; i++) begin
        vld_p[i] <= vld_p[i-1];
        seg_p[i] <= seg_p[i-1];
        sel_p[i] <= sel_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[PIPE-1];
  assign seg_out   = seg_p[PIPE-1];
  assign sel_else  = sel_p[PIPE-1];

`ifdef MODSEG_CNT_EN
  logic blank_p [PIPE];

  function automatic logic [MODSEG_CNT_W-1:0] ones(input logic [NCH-1:0] v);
    logic [MODSEG_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) n = n + MODSEG_CNT_W'(v[i]);
    return n;
  endfunction

  // Blank beats travel with a flag so the counters can skip them at the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE; i++) blank_p[i] <= 1'b0;
    end else if (advance) begin
      blank_p[0] <= (mode_c == MODE_BLANK);
      for (int i = 1; i < PIPE; i++) blank_p[i] <= blank_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_if   <= '0;
      cnt_else <= '0;
    end else if (out_valid && out_ready && !blank_p[PIPE-1]) begin
      cnt_if   <= cnt_if + ones(~sel_else);
      cnt_else <= cnt_else + ones(sel_else);
    end
  end
`endif

endmodule

// File: tb/tb_mod_segment_pipe.sv
// Self-checking bench for mod_segment_pipe: directed mode checks, stall, reset flush,
// randomized soak against a queue-based reference model, and counters when MODSEG_CNT_EN is set.
module tb_mod_segment_pipe;
  import modseg_pkg::*;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int PIPE  = 2;
  localparam int DW    = NCH * WIDTH;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_bits;
  logic [WIDTH-1:0]  zero;
  logic [DW-1:0]     ref_p;
  logic [DW-1:0]     ref_m;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     seg_out;
  logic [NCH-1:0]    sel_else;
`ifdef MODSEG_CNT_EN
  logic [15:0]       cnt_if;
  logic [15:0]       cnt_else;
`endif

  always #5 clk = ~clk;

  mod_segment_pipe #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .PIPE (PIPE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bits  (in_bits),
    .zero     (zero),
    .ref_p    (ref_p),
    .ref_m    (ref_m),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .seg_out  (seg_out),
    .sel_else (sel_else)
`ifdef MODSEG_CNT_EN
    ,
    .cnt_if   (cnt_if),
    .cnt_else (cnt_else)
`endif
  );

  typedef struct {
    logic [DW-1:0]  seg;
    logic [NCH-1:0] sel;
    bit             blank;
  } beat_t;

  beat_t          sbq[$];
  int             vectors     = 0;
  int             miscompares = 0;
  int             delivered   = 0;
  bit             stall_prev  = 1'b0;
  logic [DW-1:0]  held_seg;
  logic [NCH-1:0] held_sel;
  int unsigned    cnt_if_m    = 0;
  int unsigned    cnt_else_m  = 0;
  logic           acc, rdy;
  int             sent, base;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: per channel, decide whether the else segment is taken from the mode rules.
  function automatic beat_t predict(input logic [DW-1:0] bits, input logic [WIDTH-1:0] z,
                                    input logic [DW-1:0] p, input logic [DW-1:0] m,
                                    input logic [1:0] md);
    beat_t b;
    logic  hit, use_else;
    b.seg   = '0;
    b.sel   = '0;
    b.blank = (md == 2'd3);
    for (int k = 0; k < NCH; k++) begin
      hit      = (bits[k*WIDTH +: WIDTH] == z);
      use_else = (md == 2'd0) ? !hit : (md == 2'd1) ? hit : 1'b0;
      b.sel[k] = use_else;
      if (md != 2'd3)
        b.seg[k*WIDTH +: WIDTH] = use_else ? m[k*WIDTH +: WIDTH] : p[k*WIDTH +: WIDTH];
    end
    return b;
  endfunction

  function automatic logic [DW-1:0] pack4(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                                          input logic [WIDTH-1:0] c2, input logic [WIDTH-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic rand_inputs();
    zero = WIDTH'($urandom_range(0, 3));
    for (int k = 0; k < NCH; k++) begin
      in_bits[k*WIDTH +: WIDTH] = ($urandom_range(0, 1) == 1) ? zero : WIDTH'($urandom);
      ref_p[k*WIDTH +: WIDTH]   = WIDTH'($urandom);
      ref_m[k*WIDTH +: WIDTH]   = WIDTH'($urandom);
    end
    mode = 2'($urandom_range(0, 3));
  endtask

  // One clock cycle: drive, let it settle, score handshakes, then step past the edge.
  task automatic cycle(input logic iv, input logic ordy, output logic a, output logic r);
    logic  exp_rdy;
    beat_t b;
    in_valid  = iv;
    out_ready = ordy;
    #1;
    exp_rdy = out_ready | ~out_valid;
    check("in_ready_rule", in_ready, exp_rdy);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_seg", seg_out, held_seg);
      check("hold_sel", sel_else, held_sel);
    end
    a = in_valid & in_ready;
    r = in_ready;
    if (!reset && out_valid && out_ready) begin
      check("beat_pending", sbq.size() != 0, 1'b1);
      if (sbq.size() != 0) begin
        b = sbq.pop_front();
        check("seg_out", seg_out, b.seg);
        check("sel_else", sel_else, b.sel);
        delivered++;
        if (!b.blank) begin
          cnt_else_m += $countones(b.sel);
          cnt_if_m   += NCH - $countones(b.sel);
        end
      end
    end
    if (!reset && a) sbq.push_back(predict(in_bits, zero, ref_p, ref_m, mode));
    stall_prev = out_valid & ~out_ready & ~reset;
    held_seg   = seg_out;
    held_sel   = sel_else;
    @(posedge clk);
    #1;
    if (reset) begin
      sbq.delete();
      cnt_if_m   = 0;
      cnt_else_m = 0;
    end
`ifdef MODSEG_CNT_EN
    check("cnt_if", cnt_if, cnt_if_m[15:0]);
    check("cnt_else", cnt_else, cnt_else_m[15:0]);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b1, acc, rdy);
    cycle(1'b0, 1'b1, acc, rdy);
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sbq.size() != 0; i++) cycle(1'b0, 1'b1, acc, rdy);
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic directed(input logic [1:0] md, input logic [DW-1:0] exp_seg,
                          input logic [NCH-1:0] exp_sel);
    in_bits = pack4(32'd0, 32'd5, 32'd0, 32'd7);
    zero    = '0;
    ref_p   = pack4(32'h11, 32'h11, 32'h11, 32'h11);
    ref_m   = pack4(32'h22, 32'h22, 32'h22, 32'h22);
    mode    = md;
    cycle(1'b1, 1'b1, acc, rdy);
    for (int k = 1; k <= PIPE; k++) begin
      if (k < PIPE) begin
        check("latency_early", out_valid, 1'b0);
      end else begin
        check("latency_valid", out_valid, 1'b1);
        check("dir_seg", seg_out, exp_seg);
        check("dir_sel", sel_else, exp_sel);
      end
      cycle(1'b0, 1'b1, acc, rdy);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_bits   = '0;
    zero      = '0;
    ref_p     = '0;
    ref_m     = '0;
    mode      = MODE_NORM;
    do_reset();

    check("reset_out_valid", out_valid, 1'b0);
    check("reset_seg_out", seg_out, '0);
    check("reset_sel_else", sel_else, '0);
    check("reset_in_ready", in_ready, 1'b1);

    directed(MODE_NORM, pack4(32'h11, 32'h22, 32'h11, 32'h22), 4'b1010);
    directed(MODE_INV, pack4(32'h22, 32'h11, 32'h22, 32'h11), 4'b0101);
    directed(MODE_CARR, pack4(32'h11, 32'h11, 32'h11, 32'h11), 4'b0000);
    directed(MODE_BLANK, '0, 4'b0000);

    // Ten beats with the consumer stalled for cycles 3..6.
    sent = 0;
    base = delivered;
    for (int c = 0; c < 40 && (sent < 10 || sbq.size() != 0); c++) begin
      rand_inputs();
      cycle(sent < 10, !(c >= 3 && c <= 6), acc, rdy);
      if (acc) sent++;
      if (c >= 3 && c <= 6) check("stall_in_ready", rdy, 1'b0);
    end
    check("stall_sent", sent, 10);
    check("stall_delivered", delivered - base, 10);

    // Two beats in flight when reset hits: neither may appear.
    base = delivered;
    rand_inputs();
    cycle(1'b1, 1'b0, acc, rdy);
    rand_inputs();
    cycle(1'b1, 1'b0, acc, rdy);
    reset = 1'b1;
    cycle(1'b0, 1'b0, acc, rdy);
    reset = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_seg_out", seg_out, '0);
    cycle(1'b0, 1'b1, acc, rdy);
    check("release_in_ready", rdy, 1'b1);
    for (int i = 0; i < PIPE + 2; i++) begin
      check("flush_quiet", out_valid, 1'b0);
      cycle(1'b0, 1'b1, acc, rdy);
    end
    check("flush_delivered", delivered - base, 0);

    // Random soak with bubbles and back-pressure.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc, rdy);
    end
    drain();

`ifdef MODSEG_CNT_EN
    do_reset();
    zero    = 32'h5A;
    in_bits = pack4(32'h5A, 32'h5A, 32'h5A, 32'h5A);
    ref_p   = pack4(32'h1, 32'h2, 32'h3, 32'h4);
    ref_m   = pack4(32'h5, 32'h6, 32'h7, 32'h8);
    mode    = MODE_NORM;
    base    = delivered;
    for (int i = 0; i < 16384; i++) cycle(1'b1, 1'b1, acc, rdy);
    drain();
    check("wrap_beats", delivered - base, 16384);
    check("wrap_cnt_if", cnt_if, 16'd0);
    check("wrap_cnt_else", cnt_else, 16'd0);
    mode = MODE_BLANK;
    cycle(1'b1, 1'b1, acc, rdy);
    drain();
    check("blank_cnt_if", cnt_if, 16'd0);
    check("blank_cnt_else", cnt_else, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
